issue_queue: RTL

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/issue_queue.sv
// Four-entry in-order-select issue queue with compaction, tag wakeup
// (including dispatch-time bypass) and flush.
module issue_queue #(
  parameter int TAG_W = 5,
  parameter int OP_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [TAG_W-1:0] disp_src1,
  input  logic [TAG_W-1:0] disp_src2,
  input  logic [TAG_W-1:0] disp_dst,
  input  logic             disp_src1_rdy,
  input  logic             disp_src2_rdy,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [OP_W-1:0]  iss_op,
  output logic [TAG_W-1:0] iss_src1,
  output logic [TAG_W-1:0] iss_src2,
  output logic [TAG_W-1:0] iss_dst,
  output logic [2:0]       count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned N = 4;

  logic [N-1:0]     r_valid, r_s1r, r_s2r;
  logic [OP_W-1:0]  r_op   [N];
  logic [TAG_W-1:0] r_src1 [N];
  logic [TAG_W-1:0] r_src2 [N];
  logic [TAG_W-1:0] r_dst  [N];
  logic [2:0]       r_count;

  logic [N-1:0]     w_rdy;
  logic             w_any;
  logic [1:0]       w_sel;
  logic             w_fire;
  logic             w_accept;
  logic [2:0]       w_wr_idx;
  logic             w_d_s1r, w_d_s2r;

  logic [N-1:0]     w_n_valid, w_n_s1r, w_n_s2r;
  logic [OP_W-1:0]  w_n_op   [N];
  logic [TAG_W-1:0] w_n_src1 [N];
  logic [TAG_W-1:0] w_n_src2 [N];
  logic [TAG_W-1:0] w_n_dst  [N];

  assign count      = r_count;
  assign full       = (r_count == 3'd4);
  assign empty      = (r_count == 3'd0);
  assign disp_ready = (r_count < 3'd4);

  // Oldest ready slot wins: scan from the top so the lowest index is written last.
  always_comb begin
    w_rdy = r_valid & r_s1r & r_s2r;
    w_any = |w_rdy;
    w_sel = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (w_rdy[N-1-k]) w_sel = 2'(N - 1 - k);
    end
  end

  assign w_fire   = w_any && iss_ready;
  assign w_accept = disp_valid && disp_ready;
  assign w_wr_idx = r_count - {2'b00, w_fire};
  assign w_d_s1r  = disp_src1_rdy || (wb_valid && (wb_tag == disp_src1));
  assign w_d_s2r  = disp_src2_rdy || (wb_valid && (wb_tag == disp_src2));

  assign iss_valid = w_any;
  assign iss_op    = w_any ? r_op[w_sel]   : '0;
  assign iss_src1  = w_any ? r_src1[w_sel] : '0;
  assign iss_src2  = w_any ? r_src2[w_sel] : '0;
  assign iss_dst   = w_any ? r_dst[w_sel]  : '0;

  // Per slot: compact over the issued entry, then wake up, then drop in the dispatch.
  always_comb begin
    logic [1:0] j;
    w_n_valid = r_valid;
    w_n_s1r   = r_s1r;
    w_n_s2r   = r_s2r;
    w_n_op    = r_op;
    w_n_src1  = r_src1;
    w_n_src2  = r_src2;
    w_n_dst   = r_dst;
    for (int unsigned i = 0; i < N; i++) begin
      j = 2'(i);
      if (w_fire && (2'(i) >= w_sel) && (i < N - 1)) j = 2'(i + 1);
      w_n_op[i]    = r_op[j];
      w_n_src1[i]  = r_src1[j];
      w_n_src2[i]  = r_src2[j];
      w_n_dst[i]   = r_dst[j];
      w_n_s1r[i]   = r_s1r[j];
      w_n_s2r[i]   = r_s2r[j];
      w_n_valid[i] = (w_fire && (2'(i) >= w_sel) && (i == N - 1)) ? 1'b0 : r_valid[j];
      if (wb_valid && w_n_valid[i]) begin
        if (w_n_src1[i] == wb_tag) w_n_s1r[i] = 1'b1;
        if (w_n_src2[i] == wb_tag) w_n_s2r[i] = 1'b1;
      end
      if (w_accept && (3'(i) == w_wr_idx)) begin
        w_n_valid[i] = 1'b1;
        w_n_op[i]    = disp_op;
        w_n_src1[i]  = disp_src1;
        w_n_src2[i]  = disp_src2;
        w_n_dst[i]   = disp_dst;
        w_n_s1r[i]   = w_d_s1r;
        w_n_s2r[i]   = w_d_s2r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_s1r   <= '0;
      r_s2r   <= '0;
      r_count <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        r_op[k]   <= '0;
        r_src1[k] <= '0;
        r_src2[k] <= '0;
        r_dst[k]  <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
      r_s1r   <= '0;
      r_s2r   <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_n_valid;
      r_s1r   <= w_n_s1r;
      r_s2r   <= w_n_s2r;
      r_op    <= w_n_op;
      r_src1  <= w_n_src1;
      r_src2  <= w_n_src2;
      r_dst   <= w_n_dst;
      r_count <= r_count + {2'b00, w_accept} - {2'b00, w_fire};
    end
  end

endmodule
